write_aligner: RTL and testbench

Write-path counterpart of the DMA read aligner. It takes a packed little-endian byte stream (source byte 0 in in_data[7:0]) and an unaligned destination address. It produces word-aligned 32-bit write beats, each with a byte strobe and an aligned address, ready for the AXI4-Lite master write channel. It sits between the DMA source FIFO and the AXI write-address/write-data issue logic.

---
 rtl/write_aligner.sv | 157 +++++++++++++++
 tb/tb_write_aligner.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_aligner.sv
// write_aligner: packs an unaligned little-endian byte stream into word-aligned
// 32-bit write beats with byte strobes and aligned addresses.
module write_aligner (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] address,
  input  logic [4:0]  length,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_strb,
  output logic [31:0] out_addr,
  output logic        busy,
  output logic        done
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | accepting source words and emitting aligned beats
  // DONE  | one-cycle done pulse, then back to IDLE

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_nxt;

  logic [1:0]  off;
  logic [31:0] base;
  logic [3:0]  out_words;
  logic [3:0]  in_words;
  logic [3:0]  ld_cnt;
  logic [3:0]  out_cnt;
  logic [1:0]  last_lane;
  logic [31:0] carry;

  logic [5:0]  tot;
  logic        slot_free;
  logic        accept;
  logic        flush;
  logic        load;
  logic        out_hs;
  logic        last_hs;
  logic [31:0] beat_data;
  logic [3:0]  beat_strb;

  assign tot       = {4'd0, address[1:0]} + {1'b0, length};
  assign slot_free = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  // trailing beat made only of carried bytes once all input words are in
  assign flush     = (state == RUN) && (ld_cnt == in_words) && (ld_cnt < out_words) && slot_free;
  assign load      = accept || flush;
  assign out_hs    = out_valid && out_ready;
  assign last_hs   = out_hs && (out_cnt == out_words - 4'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (length != 5'd0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (last_hs) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == RUN);
    done     = (state == DONE);
    in_ready = (state == RUN) && (ld_cnt < in_words) && slot_free;
  end

  // beat k = ld_cnt; masked lanes are forced to zero
  always_comb begin
    int off_i;
    off_i     = int'(off);
    beat_strb = 4'hF;
    if (ld_cnt == 4'd0) begin
      beat_strb = beat_strb & (4'hF << off);
    end
    if (ld_cnt == out_words - 4'd1) begin
      beat_strb = beat_strb & (4'hF >> (2'd3 - last_lane));
    end
    beat_data = '0;
    for (int j = 0; j < 4; j++) begin
      if (beat_strb[j]) begin
        if (j >= off_i) begin
          if (!flush) begin
            beat_data[8*j +: 8] = in_data[8*(j-off_i) +: 8];
          end
        end else begin
          beat_data[8*j +: 8] = carry[8*(4-off_i+j) +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off       <= '0;
      base      <= '0;
      out_words <= '0;
      in_words  <= '0;
      last_lane <= '0;
      ld_cnt    <= '0;
      out_cnt   <= '0;
      carry     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_strb  <= '0;
      out_addr  <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        off       <= address[1:0];
        base      <= {address[31:2], 2'b00};
        out_words <= tot[5:2] + {3'd0, |tot[1:0]};
        in_words  <= {1'b0, length[4:2]} + {3'd0, |length[1:0]};
        last_lane <= tot[1:0] - 2'd1;
        ld_cnt    <= '0;
        out_cnt   <= '0;
        carry     <= '0;
      end
      if (accept) begin
        carry <= in_data;
      end
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= beat_data;
        out_strb  <= beat_strb;
        out_addr  <= base + {26'd0, ld_cnt, 2'b00};
        ld_cnt    <= ld_cnt + 4'd1;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
      if (out_hs) begin
        out_cnt <= out_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_write_aligner.sv
// Bench for write_aligner: directed vector table, reset corner cases and
// random transfers checked against a byte-address reference model.
module tb_write_aligner;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] address;
  logic [4:0]  length;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_strb;
  logic [31:0] out_addr;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  write_aligner dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .address  (address),
    .length   (length),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_strb (out_strb),
    .out_addr (out_addr),
    .busy     (busy),
    .done     (done)
  );

  typedef struct packed {
    logic [31:0]      addr;
    logic [4:0]       len;
    logic [31:0]      w0;
    logic [31:0]      w1;
    logic [1:0]       mode;
    logic [3:0]       nb;
    logic [2:0][67:0] eb;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] vec_words [8];
  logic [67:0] exp_b [16];
  int          n_exp;
  logic [67:0] cap_b [16];
  int          n_cap;

  task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [67:0] bt(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    return {a, d, s};
  endfunction

  function automatic vec_t mk(input logic [31:0] a, input int l, input logic [31:0] w0,
                              input logic [31:0] w1, input int mode, input int nb,
                              input logic [67:0] b0, input logic [67:0] b1, input logic [67:0] b2);
    vec_t v;
    v.addr = a;
    v.len  = 5'(l);
    v.w0   = w0;
    v.w1   = w1;
    v.mode = 2'(mode);
    v.nb   = 4'(nb);
    v.eb   = {b2, b1, b0};
    return v;
  endfunction

  // Destination byte at address base+4k+j holds stream byte (4k+j-off) if in range.
  task automatic model(input logic [31:0] addr, input int len);
    int          off;
    int          tot;
    logic [31:0] base;
    logic [31:0] w;
    logic [31:0] d;
    logic [3:0]  s;
    off   = int'(addr[1:0]);
    base  = {addr[31:2], 2'b00};
    tot   = off + len;
    n_exp = (len == 0) ? 0 : (tot + 3) / 4;
    for (int k = 0; k < n_exp; k++) begin
      d = '0;
      s = '0;
      for (int j = 0; j < 4; j++) begin
        int i;
        i = 4*k + j - off;
        if (i >= 0 && i < len) begin
          s[j] = 1'b1;
          w = vec_words[i/4];
          d[8*j +: 8] = w[8*(i%4) +: 8];
        end
      end
      exp_b[k] = {base + 32'(4*k), d, s};
    end
  endtask

  // mode 0: always ready/valid; 1: random handshakes; 2: first beat stalled 3 cycles
  task automatic run_xfer(input logic [31:0] addr, input logic [4:0] len, input int mode);
    int          in_idx;
    int          nwords;
    int          last_hs;
    int          done_cyc;
    int          stalls;
    int          exp_done;
    logic        prev_stall;
    logic [67:0] prev_beat;
    bit          finished;
    nwords     = (int'(len) + 3) / 4;
    n_cap      = 0;
    in_idx     = 0;
    last_hs    = 0;
    done_cyc   = -1;
    stalls     = 3;
    prev_stall = 1'b0;
    prev_beat  = '0;
    finished   = 1'b0;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        start   = 1'b1;
        address = addr;
        length  = len;
      end else begin
        start   = (mode == 1) ? ($urandom % 8 == 0) : 1'b0;
        address = $urandom;
        length  = 5'($urandom);
      end
      if (in_idx < nwords) begin
        in_valid = (mode == 1) ? ($urandom % 4 != 0) : 1'b1;
        in_data  = in_valid ? vec_words[in_idx] : $urandom;
      end else begin
        in_valid = 1'($urandom);
        in_data  = $urandom;
      end
      if (mode == 1) begin
        out_ready = ($urandom % 3 != 0);
      end else if (mode == 2 && out_valid && n_cap == 0 && stalls > 0) begin
        out_ready = 1'b0;
        stalls--;
      end else begin
        out_ready = 1'b1;
      end
      #1;
      if (cyc == 0) begin
        check("idle_in_ready", 80'(in_ready), 80'(0));
        check("idle_busy", 80'(busy), 80'(0));
      end
      if (cyc == 1 && n_exp > 0) check("run_busy", 80'(busy), 80'(1));
      if (prev_stall) check("stall_hold", {out_valid, out_addr, out_data, out_strb}, {1'b1, prev_beat});
      if (out_valid && !out_ready) check("stall_in_ready", 80'(in_ready), 80'(0));
      if (cyc > 0 && in_idx >= nwords) check("inputs_exhausted_in_ready", 80'(in_ready), 80'(0));
      if (done) begin
        check("done_without_valid", 80'(out_valid), 80'(0));
        done_cyc = cyc;
        finished = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (n_cap < 16) cap_b[n_cap] = {out_addr, out_data, out_strb};
        n_cap++;
        last_hs = cyc;
      end
      if (in_valid && in_ready) in_idx++;
      prev_stall = out_valid && !out_ready;
      prev_beat  = {out_addr, out_data, out_strb};
    end
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    exp_done  = (n_exp == 0) ? 1 : last_hs + 1;
    check("done_timing", 80'(done_cyc), 80'(exp_done));
    @(negedge clk);
    #1;
    check("done_pulse_width", 80'({done, busy}), 80'(0));
  endtask

  task automatic compare(input string tag);
    check($sformatf("%s.beats", tag), 80'(n_cap), 80'(n_exp));
    for (int k = 0; k < n_exp && k < n_cap && k < 16; k++) begin
      check($sformatf("%s.beat%0d", tag, k), 80'(cap_b[k]), 80'(exp_b[k]));
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    vec_words[0] = v.w0;
    vec_words[1] = v.w1;
    n_exp = int'(v.nb);
    for (int k = 0; k < n_exp; k++) exp_b[k] = v.eb[k];
    run_xfer(v.addr, v.len, int'(v.mode));
    compare(tag);
  endtask

  initial begin
    vec_t vecs[7];
    rst = 1'b1; start = 1'b0; address = '0; length = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    #1;
    check("reset_outputs", 80'({in_ready, out_valid, out_data, out_strb, out_addr, busy, done}), 80'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    vecs[0] = mk(32'h1000, 8, 32'h44332211, 32'h88776655, 0, 2,
                 bt(32'h1000, 32'h44332211, 4'hF), bt(32'h1004, 32'h88776655, 4'hF), '0);
    vecs[1] = mk(32'h1001, 4, 32'h44332211, 32'h0, 0, 2,
                 bt(32'h1000, 32'h33221100, 4'hE), bt(32'h1004, 32'h00000044, 4'h1), '0);
    vecs[2] = mk(32'h2003, 2, 32'hDDCCBBAA, 32'h0, 0, 2,
                 bt(32'h2000, 32'hAA000000, 4'h8), bt(32'h2004, 32'h000000BB, 4'h1), '0);
    vecs[3] = mk(32'h3002, 1, 32'h112233AA, 32'h0, 0, 1,
                 bt(32'h3000, 32'h00AA0000, 4'h4), '0, '0);
    vecs[4] = mk(32'h1001, 8, 32'h44332211, 32'h88776655, 2, 3,
                 bt(32'h1000, 32'h33221100, 4'hE), bt(32'h1004, 32'h77665544, 4'hF),
                 bt(32'h1008, 32'h00000088, 4'h1));
    vecs[5] = mk(32'hFFFFFFFE, 5, 32'h44332211, 32'hAABBCC55, 1, 2,
                 bt(32'hFFFFFFFC, 32'h22110000, 4'hC), bt(32'h00000000, 32'h00554433, 4'h7), '0);
    vecs[6] = mk(32'h0500, 0, 32'h12345678, 32'h0, 0, 0, '0, '0, '0);

    for (int v = 0; v < 7; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

    // abort a transfer with a beat pending
    @(negedge clk);
    start = 1'b1; address = 32'h1001; length = 5'd8;
    in_valid = 1'b1; in_data = 32'h44332211; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; in_data = 32'h88776655;
    @(negedge clk);
    #1;
    check("pre_reset_valid", 80'(out_valid), 80'(1));
    #2 rst = 1'b1;
    #1;
    check("mid_reset_outputs", 80'({in_ready, out_valid, out_data, out_strb, out_addr, busy, done}), 80'(0));
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check("post_reset_idle", 80'({done, busy, out_valid}), 80'(0));
    end
    run_vec(vecs[0], "after_reset");

    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      int          l;
      int          mode;
      a    = $urandom;
      l    = $urandom_range(0, 31);
      mode = ($urandom % 4 == 0) ? 0 : 1;
      if (t == 0) begin a[1:0] = 2'd3; l = 31; end
      if (t == 1) begin a[1:0] = 2'd0; l = 31; end
      if (t == 2) begin a = 32'hFFFFFFFD; l = 20; end
      for (int i = 0; i < 8; i++) vec_words[i] = $urandom;
      model(a, l);
      run_xfer(a, 5'(l), mode);
      compare($sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
